// File: rtl/rob_rc_return.sv
// Read-completion return path: round-robin merge of four cache-bank
// completions onto one registered rc channel, plus per-bank issue credits.
module rob_rc_return #(
  parameter int ROB_ID_W = 4,
  parameter int DATA_W   = 128,
  parameter int CRDT_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            b_rsp_valid,
  output logic [3:0]            b_rsp_ready,
  input  logic [4*ROB_ID_W-1:0] b_rsp_rob_id,
  input  logic [4*DATA_W-1:0]   b_rsp_data,
  output logic                  d_rc_valid,
  output logic [ROB_ID_W-1:0]   d_rc_rob_id,
  output logic [DATA_W-1:0]     d_rc_data,
  output logic [1:0]            d_rc_bank_id,
  input  logic                  isu_req,
  input  logic [1:0]            isu_bank_id,
  output logic                  isu_gnt,
  input  logic [3:0]            crdt_rtn,
  output logic [3:0]            crdt_avail,
  output logic                  crdt_err
);

  localparam int CRDT_W = $clog2(CRDT_MAX + 1);
  localparam logic [CRDT_W-1:0] CRDT_FULL = CRDT_W'(CRDT_MAX);

  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          win;
  logic                any_vld;
  logic                grant;

  logic                rc_vld_q;
  logic [ROB_ID_W-1:0] rc_id_q;
  logic [DATA_W-1:0]   rc_data_q;
  logic [1:0]          rc_bank_q;

  logic [CRDT_W-1:0]   crdt_q [4];
  logic [CRDT_W-1:0]   crdt_d [4];
  logic                err_q, err_d;

  // Scan downward so the lowest offset from rr_ptr is written last and wins.
  always_comb begin
    win     = rr_ptr_q;
    any_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (b_rsp_valid[rr_ptr_q + 2'(k)]) begin
        win     = rr_ptr_q + 2'(k);
        any_vld = 1'b1;
      end
    end
  end

  assign grant = any_vld & ~rst;

  always_comb begin
    b_rsp_ready = '0;
    if (grant) begin
      b_rsp_ready[win] = 1'b1;
    end
  end

  assign rr_ptr_d = grant ? win + 2'd1 : rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= '0;
      rc_vld_q  <= 1'b0;
      rc_id_q   <= '0;
      rc_data_q <= '0;
      rc_bank_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rc_vld_q <= |b_rsp_valid;
      if (grant) begin
        rc_id_q   <= b_rsp_rob_id[win*ROB_ID_W +: ROB_ID_W];
        rc_data_q <= b_rsp_data[win*DATA_W +: DATA_W];
        rc_bank_q <= win;
      end
    end
  end

  assign d_rc_valid   = rc_vld_q;
  assign d_rc_rob_id  = rc_id_q;
  assign d_rc_data    = rc_data_q;
  assign d_rc_bank_id = rc_bank_q;

  assign isu_gnt = isu_req & ~rst & (crdt_q[isu_bank_id] != '0);

  always_comb begin
    err_d = err_q;
    for (int i = 0; i < 4; i++) begin
      logic dec;
      logic inc;
      dec       = isu_gnt & (isu_bank_id == 2'(i));
      inc       = crdt_rtn[i];
      crdt_d[i] = crdt_q[i];
      if (inc && !dec) begin
        if (crdt_q[i] == CRDT_FULL) begin
          err_d = 1'b1;
        end else begin
          crdt_d[i] = crdt_q[i] + 1'b1;
        end
      end else if (dec && !inc) begin
        crdt_d[i] = crdt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        crdt_q[i] <= CRDT_FULL;
      end
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        crdt_q[i] <= crdt_d[i];
      end
      err_q <= err_d;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      crdt_avail[i] = (crdt_q[i] != '0);
    end
  end

  assign crdt_err = err_q;

endmodule
